rtc_field_editor: RTL and testbench
===================================

Name: rtc_field_editor

Overview:
Parametrised user-entry block for the RTC: edits clock time/date and timer time field by field, driven by the button set (escribe, aumenta, disminuye, corre_der, corre_izq).
Adds edge detection, auto-repeat, calendar-correct day limits, 12/24 h conversion, timeout exit and a commit strobe.
Feeds the RTC write path and the display mux.

Parameters:
W, 8, width of every field output (binary, unsigned); legal range W ≥ 7.
REPEAT_DLY, 50_000_000, cycles a held aumenta/disminuye must stay high before auto-repeat starts.
REPEAT_RATE, 10_000_000, cycles between auto-repeat steps.
TIMEOUT, 1_000_000_000, cycles without any accepted button action before editing auto-exits.
CNT_W, 32, width of the repeat/timeout counters; must hold max(REPEAT_DLY, TIMEOUT).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
C_T  in  1  1 = edit clock/date, 0 = edit timer
escribe, aumenta, disminuye, corre_der, corre_izq  in  1 each  synchronous button levels (already debounced)
doce_24  in  1  1 = 12 h mode (hour 1..12), 0 = 24 h mode (hour 0..23)
seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T  out  W each  field values
field_sel  out  3  current state code (0 = IDLE)
editing  out  1  high in any state other than IDLE
commit  out  1  one-cycle pulse on leaving edit mode

Behaviour:
- Reset (reset=0, async): all time fields 0; dia=1, mes=1, ano=0; state IDLE; commit=0; all counters 0. Release is synchronous to clk.
- Button conditioning:
  - Every button is rising-edge detected against a registered copy.
  - Action takes effect on the register update in the cycle the edge is seen: 1-cycle latency from input to output.
  - Auto-repeat: while aumenta or disminuye stays high, one extra step after REPEAT_DLY cycles, then one step every REPEAT_RATE cycles. Releasing the button clears the repeat counter.
- Priority, one action per cycle: escribe > aumenta > disminuye > corre_der > corre_izq.
- States (field_sel code): IDLE 0, SEG 1, MIN 2, HORA 3, DIA 4, MES 5, ANO 6.
  - IDLE: escribe edge → SEG. All other buttons are ignored.
  - Any edit state: escribe edge → IDLE and commit=1 for one cycle.
  - Navigation, C_T=1: six-state ring SEG→MIN→HORA→DIA→MES→ANO→SEG on corre_der; reverse order on corre_izq.
  - Navigation, C_T=0: three-state ring SEG↔MIN↔HORA; HORA+der → SEG, SEG+izq → HORA.
  - If C_T falls while in DIA/MES/ANO: go to SEG next cycle, no field change.
- Field target: C_T=1 selects the _C fields and the date; C_T=0 selects the _T fields. The date is never modified when C_T=0.
- Ranges; increment past max wraps to min, decrement below min wraps to max:
  - seg, min: 0..59.
  - hora: 0..23 in 24 h mode; 1..12 in 12 h mode.
  - mes: 1..12.
  - ano: 0..99 (2000–2099); leap year when ano[1:0]==0.
  - dia: 1..dim, where dim = 31/28 or 29/31/30/31/30/31/31/30/31/30/31 by month.
- Day clamp: a change to mes or ano that makes dia > dim sets dia = dim in the same register update.
- Mode conversion, on the doce_24 edge, applied to both hora_C and hora_T in any state:
  - 0→1: 0 → 12; h > 12 → h−12.
  - 1→0: value unchanged.
  - Reset value 0 while doce_24=1 is corrected to 12 on the first clock after reset.
- Timeout: in an edit state, the counter increments every cycle and clears on any accepted action. When it reaches TIMEOUT−1: → IDLE with a commit pulse. Fields are kept.
- Outputs are registered. Values held in IDLE.
- Simultaneous escribe and aumenta: only exit/entry occurs; the field is unchanged.

Decomposition:
- Package rtc_pkg holds:
  - state encoding constants;
  - field min/max constants (SEG_MAX=59, MES_MAX=12, ANO_MAX=99, HORA12_MAX=12, HORA24_MAX=23);
  - days_in_month(mes, ano) function.
- Sub-module btn_repeat (params REPEAT_DLY, REPEAT_RATE, CNT_W) outputs a step pulse. Instantiate it twice (aumenta, disminuye); plain edge detectors handle the other buttons.

Test Plan:
- Reset, escribe pulse, aumenta pulse with C_T=1 → field_sel=1, seg_C=1, editing=1; other fields at reset values.
- SEG state, seg_C=0, disminuye → seg_C=59. Timer: min_T=59, aumenta → 0.
- C_T=1: mes=2, ano=1, dia=31, decrement dia → 28. Set ano=4 with dia=28, then aumenta on dia → 29, again → 1.
- dia=31, mes=1, aumenta on mes → mes=2, dia=28 (ano=1) in the same cycle.
- hora_C=15 with doce_24=0, toggle doce_24 → 3. In 12 h mode, hora_C=12 +1 → 1.
- Reduce parameters (REPEAT_DLY=4, REPEAT_RATE=2, TIMEOUT=20): hold aumenta 9 cycles → exactly 1+3 steps. Then idle 20 cycles → field_sel=0 with one commit pulse. Assert reset mid-edit → IDLE with reset values immediately, commit stays 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared encodings and calendar helpers for the RTC field editor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rtc_pkg;

    // field_sel reports these codes directly, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEG  = 3'd1,
        ST_MIN  = 3'd2,
        ST_HORA = 3'd3,
        ST_DIA  = 3'd4,
        ST_MES  = 3'd5,
        ST_ANO  = 3'd6
    } state_e;

    localparam int SEG_MAX    = 59;
    localparam int MES_MIN    = 1;
    localparam int MES_MAX    = 12;
    localparam int DIA_MIN    = 1;
    localparam int ANO_MAX    = 99;
    localparam int HORA12_MAX = 12;
    localparam int HORA24_MAX = 23;

    // Years are 2000..2099, so a year is a leap year exactly when its two LSBs
    // are zero (2000 itself is a leap year). Only those two bits are needed.
    function automatic logic [4:0] days_in_month(input logic [3:0] mes,
                                                 input logic [1:0] ano);
        logic [4:0] d;
        case (mes)
            4'd2:                    d = (ano == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with hold-to-repeat for one button; emits single-cycle step pulses.
// Latency: step_o is combinational in the cycle the edge/repeat point is reached.
// Backpressure: none; the consumer decides whether a step is accepted.
// Ports: clk, reset (async active-low), btn_i (debounced level), step_o (step pulse).
module btn_repeat #(
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic step_o
);

    logic             btn_q;
    logic             rep_q, rep_d;   // 0: waiting out the initial delay, 1: repeating
    logic [CNT_W-1:0] cnt_q, cnt_d;   // cycles since the last step while held

    // The counter is loaded with 1 on each step, so comparing against the
    // delay/rate directly yields a step exactly that many cycles later.
    always_comb begin
        step_o = 1'b0;
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        if (!btn_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!btn_q) begin
            step_o = 1'b1;
            cnt_d  = CNT_W'(1);
            rep_d  = 1'b0;
        end else if (!rep_q) begin
            if (cnt_q == CNT_W'(REPEAT_DLY)) begin
                step_o = 1'b1;
                cnt_d  = CNT_W'(1);
                rep_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (cnt_q == CNT_W'(REPEAT_RATE)) begin
                step_o = 1'b1;
                cnt_d  = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= 1'b0;
            rep_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_i;
            rep_q <= rep_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_field_editor.sv
// Button-driven field-by-field editor for RTC clock/date and timer values, with commit strobe.
// Latency: one cycle from a button edge to the updated registered field/state outputs.
// Backpressure: none; one action per cycle by priority, lower-priority edges that cycle are dropped.
// Ports: clk, reset (async active-low), C_T (1 clock/date, 0 timer), escribe/aumenta/disminuye/
//        corre_der/corre_izq buttons, doce_24 (1 = 12 h); outputs: nine W-bit fields,
//        field_sel (state code), editing, commit (one-cycle pulse on leaving edit mode).
module rtc_field_editor
    import rtc_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000,
    parameter int unsigned TIMEOUT     = 1_000_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         C_T,
    input  logic         escribe,
    input  logic         aumenta,
    input  logic         disminuye,
    input  logic         corre_der,
    input  logic         corre_izq,
    input  logic         doce_24,
    output logic [W-1:0] seg_C,
    output logic [W-1:0] min_C,
    output logic [W-1:0] hora_C,
    output logic [W-1:0] dia,
    output logic [W-1:0] mes,
    output logic [W-1:0] ano,
    output logic [W-1:0] seg_T,
    output logic [W-1:0] min_T,
    output logic [W-1:0] hora_T,
    output logic [2:0]   field_sel,
    output logic         editing,
    output logic         commit
);

    state_e           state_q, state_d;
    logic [W-1:0]     seg_c_q, seg_c_d, min_c_q, min_c_d, hora_c_q, hora_c_d;
    logic [W-1:0]     dia_q, dia_d, mes_q, mes_d, ano_q, ano_d;
    logic [W-1:0]     seg_t_q, seg_t_d, min_t_q, min_t_d, hora_t_q, hora_t_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             commit_q, commit_d;
    logic             esc_q, der_q, izq_q, doce_q;

    logic             esc_e, der_e, izq_e, doce_rise;
    logic             up_step, dn_step;
    logic             acted;
    logic [W-1:0]     hr_min, hr_max, dim_cur, dim_new;

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_rep_up (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (aumenta),
        .step_o (up_step)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)) u_rep_dn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (disminuye),
        .step_o (dn_step)
    );

    // Step a value inside [lo, hi] with wrap-around in both directions.
    function automatic logic [W-1:0] bump(input logic [W-1:0] v, input logic [W-1:0] lo,
                                          input logic [W-1:0] hi, input logic up);
        if (up) return (v >= hi) ? lo : v + W'(1);
        else    return (v <= lo) ? hi : v - W'(1);
    endfunction

    // 24 h -> 12 h mapping: midnight becomes 12, afternoon hours drop by 12.
    function automatic logic [W-1:0] to_12h(input logic [W-1:0] h);
        if (h == '0)                   return W'(HORA12_MAX);
        else if (h > W'(HORA12_MAX))   return h - W'(HORA12_MAX);
        else                           return h;
    endfunction

    function automatic state_e nav_next(input state_e s, input logic c_t);
        case (s)
            ST_SEG:  return ST_MIN;
            ST_MIN:  return ST_HORA;
            ST_HORA: return c_t ? ST_DIA : ST_SEG;
            ST_DIA:  return ST_MES;
            ST_MES:  return ST_ANO;
            default: return ST_SEG;
        endcase
    endfunction

    function automatic state_e nav_prev(input state_e s, input logic c_t);
        case (s)
            ST_SEG:  return c_t ? ST_ANO : ST_HORA;
            ST_MIN:  return ST_SEG;
            ST_HORA: return ST_MIN;
            ST_DIA:  return ST_HORA;
            ST_MES:  return ST_DIA;
            ST_ANO:  return ST_MES;
            default: return ST_SEG;
        endcase
    endfunction

    assign esc_e     = escribe   & ~esc_q;
    assign der_e     = corre_der & ~der_q;
    assign izq_e     = corre_izq & ~izq_q;
    assign doce_rise = doce_24   & ~doce_q;
    assign hr_min    = doce_24 ? W'(1) : W'(0);
    assign hr_max    = doce_24 ? W'(HORA12_MAX) : W'(HORA24_MAX);
    assign dim_cur   = W'(days_in_month(mes_q[3:0], ano_q[1:0]));

    always_comb begin
        state_d  = state_q;
        seg_c_d  = seg_c_q;
        min_c_d  = min_c_q;
        hora_c_d = hora_c_q;
        dia_d    = dia_q;
        mes_d    = mes_q;
        ano_d    = ano_q;
        seg_t_d  = seg_t_q;
        min_t_d  = min_t_q;
        hora_t_d = hora_t_q;
        to_d     = to_q;
        commit_d = 1'b0;
        acted    = 1'b0;
        dim_new  = dim_cur;

        if (state_q == ST_IDLE) begin
            to_d = '0;
            if (esc_e) state_d = ST_SEG;
        end else if (esc_e) begin
            state_d  = ST_IDLE;
            commit_d = 1'b1;
            to_d     = '0;
        end else begin
            if (!C_T && (state_q inside {ST_DIA, ST_MES, ST_ANO})) begin
                // Timer mode has no date fields: fall back to the first field.
                state_d = ST_SEG;
            end else if (up_step || dn_step) begin
                acted = 1'b1;
                case (state_q)
                    ST_SEG: begin
                        if (C_T) seg_c_d = bump(seg_c_q, '0, W'(SEG_MAX), up_step);
                        else     seg_t_d = bump(seg_t_q, '0, W'(SEG_MAX), up_step);
                    end
                    ST_MIN: begin
                        if (C_T) min_c_d = bump(min_c_q, '0, W'(SEG_MAX), up_step);
                        else     min_t_d = bump(min_t_q, '0, W'(SEG_MAX), up_step);
                    end
                    ST_HORA: begin
                        if (C_T) hora_c_d = bump(hora_c_q, hr_min, hr_max, up_step);
                        else     hora_t_d = bump(hora_t_q, hr_min, hr_max, up_step);
                    end
                    ST_DIA: dia_d = bump(dia_q, W'(DIA_MIN), dim_cur, up_step);
                    ST_MES: begin
                        mes_d   = bump(mes_q, W'(MES_MIN), W'(MES_MAX), up_step);
                        dim_new = W'(days_in_month(mes_d[3:0], ano_q[1:0]));
                        if (dia_q > dim_new) dia_d = dim_new;
                    end
                    ST_ANO: begin
                        ano_d   = bump(ano_q, '0, W'(ANO_MAX), up_step);
                        dim_new = W'(days_in_month(mes_q[3:0], ano_d[1:0]));
                        if (dia_q > dim_new) dia_d = dim_new;
                    end
                    default: ;
                endcase
            end else if (der_e) begin
                acted   = 1'b1;
                state_d = nav_next(state_q, C_T);
            end else if (izq_e) begin
                acted   = 1'b1;
                state_d = nav_prev(state_q, C_T);
            end

            if (acted) begin
                to_d = '0;
            end else if (to_q == CNT_W'(TIMEOUT - 1)) begin
                state_d  = ST_IDLE;
                commit_d = 1'b1;
                to_d     = '0;
            end else begin
                to_d = to_q + CNT_W'(1);
            end
        end

        // Entering 12 h mode rewrites both hour registers regardless of state;
        // leaving it keeps the stored value (1..12 is already a valid 24 h hour).
        if (doce_rise) begin
            hora_c_d = to_12h(hora_c_d);
            hora_t_d = to_12h(hora_t_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            seg_c_q  <= '0;
            min_c_q  <= '0;
            hora_c_q <= '0;
            dia_q    <= W'(DIA_MIN);
            mes_q    <= W'(MES_MIN);
            ano_q    <= '0;
            seg_t_q  <= '0;
            min_t_q  <= '0;
            hora_t_q <= '0;
            to_q     <= '0;
            commit_q <= 1'b0;
            esc_q    <= 1'b0;
            der_q    <= 1'b0;
            izq_q    <= 1'b0;
            doce_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_c_q  <= seg_c_d;
            min_c_q  <= min_c_d;
            hora_c_q <= hora_c_d;
            dia_q    <= dia_d;
            mes_q    <= mes_d;
            ano_q    <= ano_d;
            seg_t_q  <= seg_t_d;
            min_t_q  <= min_t_d;
            hora_t_q <= hora_t_d;
            to_q     <= to_d;
            commit_q <= commit_d;
            esc_q    <= escribe;
            der_q    <= corre_der;
            izq_q    <= corre_izq;
            doce_q   <= doce_24;
        end
    end

    assign seg_C     = seg_c_q;
    assign min_C     = min_c_q;
    assign hora_C    = hora_c_q;
    assign dia       = dia_q;
    assign mes       = mes_q;
    assign ano       = ano_q;
    assign seg_T     = seg_t_q;
    assign min_T     = min_t_q;
    assign hora_T    = hora_t_q;
    assign field_sel = state_q;
    assign editing   = (state_q != ST_IDLE);
    assign commit    = commit_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
module tb_rtc_field_editor;

    localparam int W = 8;
    localparam int B_ESC = 0, B_UP = 1, B_DN = 2, B_DER = 3, B_IZQ = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         C_T, escribe, aumenta, disminuye, corre_der, corre_izq, doce_24;
    logic [W-1:0] seg_C, min_C, hora_C, dia, mes, ano, seg_T, min_T, hora_T;
    logic [2:0]   field_sel;
    logic         editing, commit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rtc_field_editor #(
        .W(W), .REPEAT_DLY(4), .REPEAT_RATE(2), .TIMEOUT(20), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .C_T(C_T),
        .escribe(escribe), .aumenta(aumenta), .disminuye(disminuye),
        .corre_der(corre_der), .corre_izq(corre_izq), .doce_24(doce_24),
        .seg_C(seg_C), .min_C(min_C), .hora_C(hora_C),
        .dia(dia), .mes(mes), .ano(ano),
        .seg_T(seg_T), .min_T(min_T), .hora_T(hora_T),
        .field_sel(field_sel), .editing(editing), .commit(commit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_ESC:   escribe   = v;
            B_UP:    aumenta   = v;
            B_DN:    disminuye = v;
            B_DER:   corre_der = v;
            default: corre_izq = v;
        endcase
    endtask

    task automatic press(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            set_btn(b, 1'b1);
            tick();
            set_btn(b, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        escribe = 0; aumenta = 0; disminuye = 0; corre_der = 0; corre_izq = 0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        C_T = 1; doce_24 = 0;
        escribe = 0; aumenta = 0; disminuye = 0; corre_der = 0; corre_izq = 0;
        reset = 1'b0;
        tick();
        tick();
        checks++; if (field_sel !== 3'd0) begin failures++; $display("FAIL reset_field_sel got=%0d exp=0", field_sel); end
        checks++; if (editing !== 1'b0 || commit !== 1'b0) begin failures++; $display("FAIL reset_flags got editing=%0b commit=%0b exp 0/0", editing, commit); end
        checks++; if (seg_C !== 0 || min_C !== 0 || hora_C !== 0) begin failures++; $display("FAIL reset_clock got %0d:%0d:%0d exp 0:0:0", hora_C, min_C, seg_C); end
        checks++; if (dia !== 1 || mes !== 1 || ano !== 0) begin failures++; $display("FAIL reset_date got %0d/%0d/%0d exp 1/1/0", dia, mes, ano); end
        checks++; if (seg_T !== 0 || min_T !== 0 || hora_T !== 0) begin failures++; $display("FAIL reset_timer got %0d:%0d:%0d exp 0:0:0", hora_T, min_T, seg_T); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_entry();
        do_reset();
        C_T = 1;
        escribe = 1;
        tick();
        checks++; if (field_sel !== 3'd1 || editing !== 1'b1) begin failures++; $display("FAIL entry_latency got sel=%0d editing=%0b exp 1/1", field_sel, editing); end
        escribe = 0;
        tick();
        press(B_UP, 1);
        checks++; if (seg_C !== 8'd1) begin failures++; $display("FAIL entry_inc_seg got=%0d exp=1", seg_C); end
        checks++; if (min_C !== 0 || dia !== 1 || seg_T !== 0) begin failures++; $display("FAIL entry_others got min_C=%0d dia=%0d seg_T=%0d exp 0/1/0", min_C, dia, seg_T); end
    endtask

    task automatic test_wrap();
        press(B_DN, 2);
        checks++; if (seg_C !== 8'd59) begin failures++; $display("FAIL seg_wrap_dn got=%0d exp=59", seg_C); end
        do_reset();
        C_T = 0;
        press(B_ESC, 1);
        press(B_DER, 1);
        checks++; if (field_sel !== 3'd2) begin failures++; $display("FAIL timer_nav_min got=%0d exp=2", field_sel); end
        press(B_DN, 1);
        checks++; if (min_T !== 8'd59) begin failures++; $display("FAIL min_T_wrap_dn got=%0d exp=59", min_T); end
        checks++; if (min_C !== 8'd0) begin failures++; $display("FAIL min_C_untouched got=%0d exp=0", min_C); end
        press(B_UP, 1);
        checks++; if (min_T !== 8'd0) begin failures++; $display("FAIL min_T_wrap_up got=%0d exp=0", min_T); end
        press(B_DER, 2);
        checks++; if (field_sel !== 3'd1) begin failures++; $display("FAIL timer_ring_wrap got=%0d exp=1", field_sel); end
        press(B_IZQ, 1);
        checks++; if (field_sel !== 3'd3) begin failures++; $display("FAIL timer_ring_izq got=%0d exp=3", field_sel); end
        press(B_ESC, 1);
        C_T = 1;
    endtask

    task automatic test_calendar();
        do_reset();
        C_T = 1;
        press(B_ESC, 1);
        press(B_DER, 4);
        checks++; if (field_sel !== 3'd5) begin failures++; $display("FAIL nav_to_mes got=%0d exp=5", field_sel); end
        press(B_UP, 1);
        press(B_DER, 1);
        press(B_UP, 1);
        press(B_IZQ, 2);
        checks++; if (field_sel !== 3'd4 || mes !== 2 || ano !== 1) begin failures++; $display("FAIL cal_setup got sel=%0d mes=%0d ano=%0d exp 4/2/1", field_sel, mes, ano); end
        press(B_DN, 1);
        checks++; if (dia !== 8'd28) begin failures++; $display("FAIL feb_dia_wrap got=%0d exp=28", dia); end
        press(B_DER, 2);
        press(B_UP, 3);
        checks++; if (ano !== 8'd4 || dia !== 8'd28) begin failures++; $display("FAIL leap_setup got ano=%0d dia=%0d exp 4/28", ano, dia); end
        press(B_IZQ, 2);
        press(B_UP, 1);
        checks++; if (dia !== 8'd29) begin failures++; $display("FAIL leap_dia_29 got=%0d exp=29", dia); end
        press(B_UP, 1);
        checks++; if (dia !== 8'd1) begin failures++; $display("FAIL leap_dia_wrap got=%0d exp=1", dia); end
        press(B_ESC, 1);
    endtask

    task automatic test_clamp();
        do_reset();
        C_T = 1;
        press(B_ESC, 1);
        press(B_DER, 3);
        press(B_DN, 1);
        checks++; if (dia !== 8'd31) begin failures++; $display("FAIL jan_dia_wrap got=%0d exp=31", dia); end
        press(B_DER, 2);
        press(B_UP, 1);
        press(B_IZQ, 1);
        aumenta = 1;
        tick();
        checks++; if (mes !== 8'd2 || dia !== 8'd28) begin failures++; $display("FAIL day_clamp got mes=%0d dia=%0d exp 2/28", mes, dia); end
        aumenta = 0;
        tick();
        C_T = 0;
        tick();
        checks++; if (field_sel !== 3'd1 || mes !== 8'd2) begin failures++; $display("FAIL ct_fall got sel=%0d mes=%0d exp 1/2", field_sel, mes); end
        escribe = 1;
        tick();
        checks++; if (field_sel !== 3'd0 || commit !== 1'b1) begin failures++; $display("FAIL exit_commit got sel=%0d commit=%0b exp 0/1", field_sel, commit); end
        escribe = 0;
        tick();
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL commit_one_cycle got=%0b exp=0", commit); end
        C_T = 1;
    endtask

    task automatic test_hour_mode();
        doce_24 = 0;
        do_reset();
        C_T = 1;
        press(B_ESC, 1);
        press(B_DER, 2);
        press(B_DN, 9);
        checks++; if (hora_C !== 8'd15) begin failures++; $display("FAIL hora_24_dn got=%0d exp=15", hora_C); end
        doce_24 = 1;
        tick();
        checks++; if (hora_C !== 8'd3) begin failures++; $display("FAIL conv_15_to_3 got=%0d exp=3", hora_C); end
        checks++; if (hora_T !== 8'd12) begin failures++; $display("FAIL conv_T_0_to_12 got=%0d exp=12", hora_T); end
        press(B_UP, 9);
        checks++; if (hora_C !== 8'd12) begin failures++; $display("FAIL hora_12_up got=%0d exp=12", hora_C); end
        press(B_UP, 1);
        checks++; if (hora_C !== 8'd1) begin failures++; $display("FAIL hora_12_wrap got=%0d exp=1", hora_C); end
        press(B_ESC, 1);
        reset = 1'b0;
        tick();
        checks++; if (hora_C !== 8'd0) begin failures++; $display("FAIL hora_in_reset got=%0d exp=0", hora_C); end
        reset = 1'b1;
        tick();
        checks++; if (hora_C !== 8'd12 || hora_T !== 8'd12) begin failures++; $display("FAIL reset_12h_fix got C=%0d T=%0d exp 12/12", hora_C, hora_T); end
        doce_24 = 0;
        tick();
        checks++; if (hora_C !== 8'd12) begin failures++; $display("FAIL conv_back_24 got=%0d exp=12", hora_C); end
    endtask

    task automatic test_repeat_timeout();
        int pulses;
        doce_24 = 0;
        do_reset();
        C_T = 1;
        press(B_ESC, 1);
        aumenta = 1;
        repeat (9) tick();
        checks++; if (seg_C !== 8'd4) begin failures++; $display("FAIL repeat_steps got=%0d exp=4", seg_C); end
        aumenta = 0;
        tick();
        checks++; if (seg_C !== 8'd4) begin failures++; $display("FAIL repeat_release got=%0d exp=4", seg_C); end
        pulses = 0;
        repeat (18) begin
            tick();
            if (commit === 1'b1) pulses++;
        end
        checks++; if (field_sel !== 3'd1 || pulses != 0) begin failures++; $display("FAIL timeout_early got sel=%0d pulses=%0d exp 1/0", field_sel, pulses); end
        tick();
        checks++; if (field_sel !== 3'd0 || commit !== 1'b1 || seg_C !== 8'd4) begin failures++; $display("FAIL timeout_exit got sel=%0d commit=%0b seg=%0d exp 0/1/4", field_sel, commit, seg_C); end
        tick();
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL timeout_pulse_len got=%0b exp=0", commit); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        C_T = 1;
        escribe = 1; aumenta = 1;
        tick();
        checks++; if (field_sel !== 3'd1 || seg_C !== 8'd0) begin failures++; $display("FAIL esc_up_entry got sel=%0d seg=%0d exp 1/0", field_sel, seg_C); end
        escribe = 0; aumenta = 0;
        tick();
        press(B_UP, 1);
        escribe = 1; aumenta = 1;
        tick();
        checks++; if (field_sel !== 3'd0 || commit !== 1'b1 || seg_C !== 8'd1) begin failures++; $display("FAIL esc_up_exit got sel=%0d commit=%0b seg=%0d exp 0/1/1", field_sel, commit, seg_C); end
        escribe = 0; aumenta = 0;
        tick();
        press(B_ESC, 1);
        press(B_UP, 1);
        reset = 1'b0;
        #2;
        checks++; if (field_sel !== 3'd0 || seg_C !== 8'd0 || commit !== 1'b0) begin failures++; $display("FAIL async_reset got sel=%0d seg=%0d commit=%0b exp 0/0/0", field_sel, seg_C, commit); end
        tick();
        checks++; if (commit !== 1'b0 || editing !== 1'b0) begin failures++; $display("FAIL reset_hold got commit=%0b editing=%0b exp 0/0", commit, editing); end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_entry();
        test_wrap();
        test_calendar();
        test_clamp();
        test_hour_mode();
        test_repeat_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
